results_conv_sched: RTL

Frame scheduler that shares the single results_conv write port between NUM_REQ result producers. It grants one requester per frame using round-robin arbitration. It then sequences FRAME_WORDS writes (address 0..FRAME_WORDS-1) with the 4-cycle setup/strobe protocol on address/din/rcc_clk. It enforces GAP_CYCLES idle cycles after each frame so the converter can finish serialising digits before the next frame.

---
 rtl/results_conv_pkg.sv | 22 ++
 rtl/results_conv_sched_if.sv | 26 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/results_conv_sched.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/results_conv_pkg.sv
// Shared types and constants for the results_conv frame scheduler.
package results_conv_pkg;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StSetup    = 3'd1,
        StStrobeHi = 3'd2,
        StStrobeLo = 3'd3,
        StHold     = 3'd4,
        StGap      = 3'd5
    } sched_state_e;

    localparam int unsigned WR_CYCLES       = 4;
    localparam int unsigned FRAME_WORDS_DEF = 9;
    localparam int unsigned GAP_CYCLES_DEF  = 160;

    // Counter width that never collapses to zero bits.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/results_conv_sched_if.sv
// Requester and converter-side signals of the results_conv frame scheduler.
interface results_conv_sched_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned DW      = 16
);
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_din;
    logic [NUM_REQ-1:0]    grant;
    logic [3:0]            word_idx;
    logic [3:0]            address;
    logic [DW-1:0]         din;
    logic                  din_oe;
    logic                  rcc_clk;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output req, req_din,
        input  grant, word_idx, address, din, din_oe, rcc_clk, busy, frame_done
    );

    modport slave (
        input  req, req_din,
        output grant, word_idx, address, din, din_oe, rcc_clk, busy, frame_done
    );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping.
module rr_arbiter
    import results_conv_pkg::*;
#(
    parameter int unsigned  NUM_REQ = 2,
    localparam int unsigned PtrW    = clog2_min1(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PtrW-1:0]    ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [PtrW-1:0]    idx_o,
    output logic               valid_o
);

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        // Upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (i >= int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = PtrW'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid_o && req_i[i] && (i < int'(ptr_i))) begin
                valid_o    = 1'b1;
                grant_o[i] = 1'b1;
                idx_o      = PtrW'(i);
            end
        end
    end

endmodule

// File: rtl/results_conv_sched.sv
// Frame scheduler sharing the results_conv write port among NUM_REQ producers:
// round-robin grant per frame, 4-cycle setup/strobe writes, then an idle gap.
module results_conv_sched
    import results_conv_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 2,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned GAP_CYCLES  = GAP_CYCLES_DEF,
    parameter int unsigned DW          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    results_conv_sched_if.slave  bus
);

    localparam int unsigned PtrW     = clog2_min1(NUM_REQ);
    localparam int unsigned GapW     = clog2_min1(GAP_CYCLES + 1);
    localparam logic [3:0]  LastWord = 4'(FRAME_WORDS - 1);
    localparam logic [GapW-1:0] GapLoad = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

    sched_state_e        state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [PtrW-1:0]     grant_idx_q, grant_idx_d;
    logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [3:0]          word_idx_q, word_idx_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [3:0]          address_q, address_d;
    logic [DW-1:0]       din_q, din_d;
    logic                din_oe_q, din_oe_d;
    logic                rcc_clk_q, rcc_clk_d;

    logic [NUM_REQ-1:0]  arb_grant;
    logic [PtrW-1:0]     arb_idx;
    logic                arb_valid;
    logic [DW-1:0]       sel_din;
    logic                last_word;
    logic                gap_zero;
    logic                start_frame;
    logic                frame_end;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .req_i   (bus.req),
        .ptr_i   (rr_ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    assign last_word   = (word_idx_q == LastWord);
    assign gap_zero    = (gap_cnt_q == '0);
    assign start_frame = enable && arb_valid;
    // Frame ends leaving the last GAP cycle, or leaving the last HOLD without a gap.
    assign frame_end   = ((state_q == StGap) && gap_zero) ||
                         ((GAP_CYCLES == 0) && (state_q == StHold) && last_word);

    always_comb begin
        sel_din = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx_q == PtrW'(i)) begin
                sel_din = bus.req_din[i*DW +: DW];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (start_frame) state_d = StSetup;
            StSetup:    state_d = StStrobeHi;
            StStrobeHi: state_d = StStrobeLo;
            StStrobeLo: state_d = StHold;
            StHold: begin
                if (!last_word) begin
                    state_d = StSetup;
                end else if (GAP_CYCLES == 0) begin
                    state_d = StIdle;
                end else begin
                    state_d = StGap;
                end
            end
            StGap:      if (gap_zero) state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        word_idx_d  = word_idx_q;
        gap_cnt_d   = gap_cnt_q;
        address_d   = address_q;
        din_d       = din_q;
        din_oe_d    = din_oe_q;
        rcc_clk_d   = (state_q == StStrobeHi);

        unique case (state_q)
            StIdle: begin
                if (start_frame) begin
                    grant_d     = arb_grant;
                    grant_idx_d = arb_idx;
                    word_idx_d  = '0;
                end
            end
            StSetup: begin
                address_d = word_idx_q;
                din_d     = sel_din;
                din_oe_d  = 1'b1;
            end
            StHold: begin
                din_oe_d = 1'b0;
                if (!last_word) begin
                    word_idx_d = word_idx_q + 4'd1;
                end else begin
                    address_d  = '0;
                    word_idx_d = '0;
                    gap_cnt_d  = GapLoad;
                end
            end
            StGap: begin
                if (!gap_zero) gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: ;
        endcase

        if (frame_end) begin
            grant_d = '0;
            if (32'(grant_idx_q) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q     <= '0;
            grant_idx_q <= '0;
            rr_ptr_q    <= '0;
            word_idx_q  <= '0;
            gap_cnt_q   <= '0;
            address_q   <= '0;
            din_q       <= '0;
            din_oe_q    <= 1'b0;
            rcc_clk_q   <= 1'b0;
        end else begin
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            rr_ptr_q    <= rr_ptr_d;
            word_idx_q  <= word_idx_d;
            gap_cnt_q   <= gap_cnt_d;
            address_q   <= address_d;
            din_q       <= din_d;
            din_oe_q    <= din_oe_d;
            rcc_clk_q   <= rcc_clk_d;
        end
    end

    // Outputs
    always_comb begin
        bus.grant      = grant_q;
        bus.word_idx   = word_idx_q;
        bus.address    = address_q;
        bus.din        = din_q;
        bus.din_oe     = din_oe_q;
        bus.rcc_clk    = rcc_clk_q;
        bus.busy       = (state_q != StIdle);
        bus.frame_done = frame_end;
    end

endmodule
